// File: rtl/rv32v_types_pkg.sv
// Shared RV32V types: element width, element offset, writeback FSM states.
// Define RV32V_WB_SCOREBOARD_EN to build the vd_busy group-mask logic.
package rv32v_types_pkg;

   typedef enum logic [1:0] {
      SEW8  = 2'd0,
      SEW16 = 2'd1,
      SEW32 = 2'd2
   } sew_t;

   typedef logic [6:0] offset_t;

   localparam int VLEN_BYTES = 16;
   localparam int MAX_LMUL   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } vwb_state_t;

endpackage

// File: rtl/rv32v_vreg_group_mask.sv
// Register-group mask: marks the G registers an instruction writes,
// starting at vd and wrapping modulo 32. Used by RV32V_WB_SCOREBOARD_EN.
module rv32v_vreg_group_mask
   import rv32v_types_pkg::*;
#(
   parameter int VL_W = 8
) (
   input  logic [4:0]      vd,
   input  sew_t            eew,
   input  logic [VL_W-1:0] vl,
   output logic [31:0]     mask
);

   localparam int BW = VL_W + 2;
   localparam int SH = $clog2(VLEN_BYTES);

   logic [BW-1:0] bytes;
   logic [BW-1:0] g_raw;
   logic [3:0]    g;

   // Group size: bytes written rounded up to whole registers, capped at MAX_LMUL
   always_comb begin
      bytes = {2'b00, vl} << eew;
      g_raw = (bytes + BW'(VLEN_BYTES - 1)) >> SH;
      g     = (g_raw > BW'(MAX_LMUL)) ? 4'(MAX_LMUL) : 4'(g_raw);
   end

   // One bit per register in the group, indices wrap at 32
   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LMUL; i++) begin
         if (4'(i) < g) mask[5'(vd + 5'(i))] = 1'b1;
      end
   end

endmodule

// File: rtl/rv32v_vd_writeback.sv
// Vector destination writeback: two elements per beat into the RF write port.
// Define RV32V_WB_SCOREBOARD_EN to drive vd_busy; otherwise it is tied to 0.
module rv32v_vd_writeback
   import rv32v_types_pkg::*;
#(
   parameter int NUM_LANES = 2,
   parameter int VL_W      = 8
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  start,
   output logic                  start_ready,
   input  logic [4:0]            start_vd,
   input  sew_t                  start_eew,
   input  logic [VL_W-1:0]       start_vl,
   input  logic [VL_W-1:0]       start_vstart,
   input  logic                  flush,
   input  logic                  res_valid,
   output logic                  res_ready,
   input  logic [1:0][31:0]      res_data,
   output logic                  wen,
   output logic [4:0]            vd,
   output offset_t               vd_offset,
   output sew_t                  eew,
   output logic [VL_W-1:0]       vl,
   output logic [1:0][31:0]      w_data,
   output logic                  done,
   output logic [31:0]           vd_busy
);

   localparam int STEP = NUM_LANES;

   vwb_state_t      state, state_n;
   logic [VL_W-1:0] ofs;
   logic [VL_W:0]   ofs_nxt;
   logic            accept;
   logic            start_go;
   logic            empty;
   logic            wen_q;

   assign start_ready = (state == IDLE);
   assign res_ready   = (state == RUN) && !flush;
   assign accept      = res_ready && res_valid;
   assign start_go    = start && start_ready && !flush;
   assign empty       = (start_vl == '0) || (start_vstart >= start_vl);
   assign ofs_nxt     = {1'b0, ofs} + (VL_W+1)'(STEP);
   assign wen         = wen_q && !flush;
   assign done        = (state == DONE) && !flush;

   // Next state; flush wins over everything, including a same-cycle start
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (start_go) state_n = empty ? DONE : RUN;
         RUN:     if (accept && (ofs_nxt >= {1'b0, vl})) state_n = FINAL;
         FINAL:   state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (flush) state_n = IDLE;
   end

   // State, instruction setup, element offset and registered write port
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= IDLE;
         ofs       <= '0;
         wen_q     <= 1'b0;
         vd        <= '0;
         vd_offset <= '0;
         eew       <= SEW8;
         vl        <= '0;
         w_data    <= '0;
      end else begin
         state <= state_n;
         wen_q <= accept;
         if (start_go) begin
            vd  <= start_vd;
            eew <= start_eew;
            vl  <= start_vl;
            ofs <= start_vstart;
         end
         if (accept) begin
            vd_offset <= ofs[6:0];
            w_data    <= res_data;
            ofs       <= ofs_nxt[VL_W-1:0];
         end
      end
   end

`ifdef RV32V_WB_SCOREBOARD_EN
   logic [31:0] grp_mask;

   rv32v_vreg_group_mask #(
      .VL_W (VL_W)
   ) u_mask (
      .vd   (start_vd),
      .eew  (start_eew),
      .vl   (start_vl),
      .mask (grp_mask)
   );

   // Busy mask held from the cycle after start until the cycle after done
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         vd_busy <= '0;
      end else if (flush || (state == DONE)) begin
         vd_busy <= '0;
      end else if (start_go) begin
         vd_busy <= grp_mask;
      end
   end
`else
   assign vd_busy = '0;
`endif

endmodule

// File: tb/tb_rv32v_vd_writeback.sv
// Directed bench for rv32v_vd_writeback with a write scoreboard.
// Busy-mask expectations follow RV32V_WB_SCOREBOARD_EN.
module tb_rv32v_vd_writeback;
   import rv32v_types_pkg::*;

`ifdef RV32V_WB_SCOREBOARD_EN
   localparam bit SB = 1'b1;
`else
   localparam bit SB = 1'b0;
`endif

   logic            CLK = 1'b0;
   logic            nRST = 1'b0;
   logic            start = 1'b0;
   logic            start_ready;
   logic [4:0]      start_vd = '0;
   sew_t            start_eew = SEW8;
   logic [7:0]      start_vl = '0;
   logic [7:0]      start_vstart = '0;
   logic            flush = 1'b0;
   logic            res_valid = 1'b0;
   logic            res_ready;
   logic [1:0][31:0] res_data = '0;
   logic            wen;
   logic [4:0]      vd;
   offset_t         vd_offset;
   sew_t            eew;
   logic [7:0]      vl;
   logic [1:0][31:0] w_data;
   logic            done;
   logic [31:0]     vd_busy;

   int checks = 0;
   int errors = 0;
   logic [31:0] cyc = '0;
   logic [117:0] sb[$];

   rv32v_vd_writeback #(
      .NUM_LANES (2),
      .VL_W      (8)
   ) dut (
      .CLK          (CLK),
      .nRST         (nRST),
      .start        (start),
      .start_ready  (start_ready),
      .start_vd     (start_vd),
      .start_eew    (start_eew),
      .start_vl     (start_vl),
      .start_vstart (start_vstart),
      .flush        (flush),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_data     (res_data),
      .wen          (wen),
      .vd           (vd),
      .vd_offset    (vd_offset),
      .eew          (eew),
      .vl           (vl),
      .w_data       (w_data),
      .done         (done),
      .vd_busy      (vd_busy)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 32'd1;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Every write seen on the RF port must match the oldest expected write
   always @(negedge CLK) begin
      if (wen === 1'b1) begin
         chk("wen_expected", 128'(sb.size() != 0), 128'(1));
         if (sb.size() != 0) begin
            logic [117:0] e;
            e = sb.pop_front();
            chk("rf_write",
                {10'b0, vd, vd_offset, w_data, eew, vl, cyc},
                {10'b0, e});
         end
      end
   end

   task automatic run(input logic [4:0] v, input sew_t e,
                      input logic [7:0] l, input logic [7:0] vs,
                      input bit tog, input logic [31:0] busy);
      int acc_n, exp_n, last_acc, done_cyc, start_cyc;
      bit got;
      logic [7:0]  m_ofs;
      logic [31:0] a, b;
      acc_n = 0;
      got = 1'b0;
      last_acc = 0;
      done_cyc = 0;
      exp_n = (vs < l) ? (int'(l) - int'(vs) + 1) / 2 : 0;
      chk("start_ready", 128'(start_ready), 128'(1));
      start = 1'b1;
      start_vd = v;
      start_eew = e;
      start_vl = l;
      start_vstart = vs;
      m_ofs = vs;
      tick();
      start = 1'b0;
      start_cyc = int'(cyc);
      for (int i = 0; i < 64 && !got; i++) begin
         res_valid = tog ? (i % 2 == 0) : 1'b1;
         a = $urandom;
         b = $urandom;
         res_data[0] = a;
         res_data[1] = b;
         #3;
         if (i == 0) chk("vd_busy_run", 128'(vd_busy), 128'(busy));
         if (done === 1'b1) begin
            got = 1'b1;
            done_cyc = int'(cyc);
         end else if (res_valid && res_ready === 1'b1) begin
            sb.push_back({v, m_ofs[6:0], b, a, e, l, cyc + 32'd1});
            m_ofs = m_ofs + 8'd2;
            acc_n++;
            last_acc = int'(cyc);
         end
         tick();
      end
      res_valid = 1'b0;
      chk("done_seen", 128'(got), 128'(1));
      chk("beats", 128'(acc_n), 128'(exp_n));
      chk("done_lat",
          128'(done_cyc - ((exp_n != 0) ? last_acc : start_cyc)),
          128'((exp_n != 0) ? 2 : 0));
      chk("done_pulse", 128'(done), 128'(0));
      chk("ready_after", 128'(start_ready), 128'(1));
      chk("busy_after", 128'(vd_busy), 128'(0));
      chk("sb_empty", 128'(sb.size()), 128'(0));
   endtask

   initial begin
      #2;
      chk("rst_ctl", 128'({wen, done, res_ready}), 128'(0));
      chk("rst_outs",
          128'({vd, vd_offset, eew, vl, w_data, vd_busy}), 128'(0));
      #10;
      nRST = 1'b1;
      tick();
      chk("rst_ready", 128'(start_ready), 128'(1));

      run(5'd4, SEW32, 8'd5, 8'd0, 1'b0, SB ? 32'h0000_0030 : 32'h0);
      run(5'd1, SEW8, 8'd0, 8'd0, 1'b0, 32'h0);
      run(5'd7, SEW16, 8'd8, 8'd4, 1'b1, SB ? 32'h0000_0080 : 32'h0);
      run(5'd3, SEW8, 8'd4, 8'd6, 1'b0, SB ? 32'h0000_0008 : 32'h0);

      start = 1'b1;
      start_vd = 5'd2;
      start_eew = SEW32;
      start_vl = 8'd8;
      start_vstart = 8'd0;
      tick();
      start = 1'b0;
      res_valid = 1'b1;
      res_data[0] = 32'hdead_0001;
      res_data[1] = 32'hdead_0002;
      #3;
      chk("fl_accept", 128'(res_ready), 128'(1));
      tick();
      res_valid = 1'b0;
      flush = 1'b1;
      #3;
      chk("fl_wen", 128'(wen), 128'(0));
      chk("fl_done", 128'(done), 128'(0));
      tick();
      flush = 1'b0;
      #3;
      chk("fl_ready", 128'(start_ready), 128'(1));
      chk("fl_busy", 128'(vd_busy), 128'(0));
      chk("fl_done2", 128'(done), 128'(0));
      tick();
      tick();

      run(5'd30, SEW32, 8'd16, 8'd0, 1'b0, SB ? 32'hC000_0003 : 32'h0);

      start = 1'b1;
      start_vd = 5'd9;
      start_eew = SEW16;
      start_vl = 8'd10;
      start_vstart = 8'd0;
      tick();
      start = 1'b0;
      res_valid = 1'b1;
      #3;
      chk("mr_accept", 128'(res_ready), 128'(1));
      tick();
      nRST = 1'b0;
      #1;
      chk("mr_ctl", 128'({wen, done, res_ready}), 128'(0));
      chk("mr_outs",
          128'({vd, vd_offset, eew, vl, w_data, vd_busy}), 128'(0));
      res_valid = 1'b0;
      sb.delete();
      tick();
      nRST = 1'b1;
      tick();
      run(5'd0, SEW32, 8'd3, 8'd0, 1'b0, SB ? 32'h0000_0001 : 32'h0);

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv32v_vd_writeback.md
# rv32v_vd_writeback

Write-side driver for the vector register file write port. Accepts per-instruction setup (vd, eew, vl, vstart) and a stream of two-lane element results from the execute lanes, and issues one register-file write per accepted beat. Walks the element offset two elements per beat, terminates at vl, and signals completion to the vector control unit. Sits between the vector execute lanes and the register file `rv32v_reg_file_if`.

## Interface
Parameters:
- `NUM_LANES`, 2: elements per beat; only 2 is supported.
- `VL_W`, 8: width of vl/vstart; covers vl up to 128.

Ports:
- `CLK`  in  1  clock
- `nRST`  in  1  reset; asynchronous, active-low
- `start`  in  1  begin instruction; taken only when `start_ready`
- `start_ready`  out  1  high in IDLE
- `start_vd`  in  5  destination base register
- `start_eew`  in  sew_t  element width (SEW8/16/32)
- `start_vl`  in  VL_W  vector length
- `start_vstart`  in  VL_W  first element index
- `flush`  in  1  abort current instruction
- `res_valid`  in  1  result beat valid
- `res_ready`  out  1  result beat accepted when both high
- `res_data`  in  [1:0][31:0]  lane 0/1 results, low bits significant per eew
- `wen`  out  1  register-file write enable
- `vd`  out  5  to RF
- `vd_offset`  out  offset_t (7)  lane-0 element index
- `eew`  out  sew_t  to RF
- `vl`  out  VL_W  to RF (gates lane writes at element ≥ vl)
- `w_data`  out  [1:0][31:0]  to RF
- `done`  out  1  one-cycle completion pulse
- `vd_busy`  out  32  per-register write-pending mask

## Operation
- FSM states: IDLE, RUN, FINAL, DONE.
- IDLE: `start_ready`=1. On `start`: latch vd/eew/vl; `ofs` ← vstart. If vl==0 or vstart≥vl → DONE; else → RUN.
- RUN: `res_ready`=1. On beat accept: capture `res_data` and `ofs` into output register; `ofs` ← ofs+2. If ofs+2 ≥ vl → FINAL, else stay.
- FINAL: `res_ready`=0; the final write drains; → DONE.
- DONE: `done`=1 for one cycle; → IDLE.
- `wen` is registered: high in the cycle after each accepted beat, with `vd_offset`, `w_data` from that beat. RF never stalls.
- Odd tail (ofs+1 == vl): lane 1 data forwarded unchanged; RF suppresses the write via vl.
- Offset arithmetic: ofs is VL_W bits, no wrap; `vd_offset` = ofs[6:0].
- `flush` (any state): → IDLE next cycle, `wen` of the in-flight beat is cancelled, no `done`, `vd_busy` cleared. `flush` overrides simultaneous `start`.
- `start` outside IDLE is ignored.
- Reset: state IDLE; `wen`, `done`, `res_ready`=0; `start_ready`=1 after reset release; `vd`, `vd_offset`, `eew`, `vl`, `w_data`, `vd_busy` = 0.

## Timing
- Beat accepted in cycle N → `wen` in N+1. Throughput one beat per cycle.
- Last beat accepted in N → FINAL in N+1 (last `wen`) → `done` in N+2 → `start_ready` in N+3.
- Empty instruction (vl==0): `start` in N → `done` in N+1, no `wen`.

## Configuration
- `RV32V_WB_SCOREBOARD_EN` defined:
  - `vd_busy` bit r is set for vd ≤ r < vd+G from the cycle after `start` until the cycle after `done`.
  - G = ceil(vl·eew_bytes / VLEN_BYTES), clamped to 1..8; G=0 when vl==0.
  - Bits index modulo 32.
- Undefined: `vd_busy` tied to 0; no group-mask logic.

## Structure
- In `rv32v_types_pkg`:
  - reuse `sew_t` and `offset_t`.
  - add constants `VLEN_BYTES`=16 and `MAX_LMUL`=8.
  - add enum `vwb_state_t` {IDLE, RUN, FINAL, DONE}.
- Sub-module `rv32v_vreg_group_mask` (combinational: vd, eew, vl → 32-bit mask). Instantiated only under `RV32V_WB_SCOREBOARD_EN`.

## Test plan
- SEW32, vd=4, vl=5, vstart=0, beats each cycle → `wen` with offsets 0,2,4; `done` 2 cycles after 3rd accept; RF v4 holds elements 0–3, v5 holds element 4.
- SEW8, vl=0 → `done` next cycle; no `wen`; `vd_busy`=0.
- SEW16, vl=8, vstart=4, `res_valid` toggling 1/0 → exactly 2 `wen` (offsets 4, 6), each one cycle after its accept.
- `flush` asserted the cycle after 1st accept of a vl=8 run → that `wen` is suppressed, no `done`, `start_ready`=1 next cycle.
- Scoreboard build, SEW32, vd=30, vl=16 → G=4; `vd_busy` = bits 30, 31, 0, 1 during the run; 0 after `done`.
- `nRST` low mid-RUN → all outputs at reset values immediately; a fresh `start` after release runs normally.
